// File: rtl/wb_csr_bank_if.sv
// rtl/wb_csr_bank_if.sv - Wishbone classic CSR bus bundle (7-bit address, 8-bit data)
interface wb_csr_bank_if;
  logic [6:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_we_i;
  logic       wb_stb_i;
  logic       wb_cyc_i;
  logic       wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_csr_bank.sv
// rtl/wb_csr_bank.sv - Wishbone CSR slave: RW bank, ID, free-running counter, W1C event/IRQ block
module wb_csr_bank #(
  parameter int         NUM_RW      = 16,
  parameter logic [7:0] RW_RESET    = 8'h00,
  parameter logic [7:0] ID_VALUE    = 8'hA5,
  parameter int         WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_csr_bank_if.slave          wb,
  output logic [8*NUM_RW-1:0]   csr_q,
  output logic [NUM_RW-1:0]     csr_wr_o,
  input  logic [7:0]            evt_i,
  output logic                  irq_o
);

  localparam logic [6:0] ADR_ID     = 7'h70;
  localparam logic [6:0] ADR_CNT    = 7'h71;
  localparam logic [6:0] ADR_STATUS = 7'h72;
  localparam logic [6:0] ADR_MASK   = 7'h73;
  localparam logic [3:0] WAIT_LAST  = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic [6:0] adr_q;
  logic       we_q;
  logic [7:0] dat_q;
  logic [7:0] snap_q;
  logic [7:0] cnt;
  logic [7:0] evt_status;
  logic [7:0] evt_mask;
  logic [7:0] evt_prev;
  logic [7:0] csr [NUM_RW];

  logic       req;
  logic       commit;
  logic       c_we;
  logic [6:0] c_adr;
  logic [7:0] c_dat;
  logic [7:0] c_cnt;
  logic [7:0] rd_data;
  logic [7:0] w1c;
  logic [7:0] evt_rise;

  assign req      = wb.wb_stb_i & wb.wb_cyc_i;
  assign evt_rise = evt_i & ~evt_prev;

  // Zero wait states commit straight off the bus in IDLE; otherwise from the E0 latches.
  always_comb begin
    c_adr  = (state == IDLE) ? wb.wb_adr_i : adr_q;
    c_we   = (state == IDLE) ? wb.wb_we_i  : we_q;
    c_dat  = (state == IDLE) ? wb.wb_dat_i : dat_q;
    c_cnt  = (state == IDLE) ? cnt         : snap_q;
    commit = ((state == IDLE) && req && (WAIT_CYCLES == 0)) ||
             ((state == WAIT) && wb.wb_cyc_i && (wait_cnt == WAIT_LAST));
  end

  always_comb begin
    rd_data = 8'h00;
    for (int n = 0; n < NUM_RW; n++) begin
      if (c_adr == 7'(n)) rd_data = csr[n];
    end
    case (c_adr)
      ADR_ID:     rd_data = ID_VALUE;
      ADR_CNT:    rd_data = c_cnt;
      ADR_STATUS: rd_data = evt_status;
      ADR_MASK:   rd_data = evt_mask;
      default:    ;
    endcase
  end

  always_comb begin
    w1c = 8'h00;
    if (commit && c_we && (c_adr == ADR_STATUS)) w1c = c_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      adr_q       <= 7'd0;
      we_q        <= 1'b0;
      dat_q       <= 8'd0;
      snap_q      <= 8'd0;
      cnt         <= 8'd0;
      evt_status  <= 8'd0;
      evt_mask    <= 8'd0;
      evt_prev    <= 8'd0;
      irq_o       <= 1'b0;
      csr_wr_o    <= '0;
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= 8'd0;
      for (int n = 0; n < NUM_RW; n++) csr[n] <= RW_RESET;
    end else begin
      cnt         <= cnt + 8'd1;
      evt_prev    <= evt_i;
      // A rising edge in the same cycle as a W1C clear keeps the bit set.
      evt_status  <= (evt_status & ~w1c) | evt_rise;
      irq_o       <= |(evt_status & evt_mask);
      csr_wr_o    <= '0;
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= 8'd0;

      if (commit) begin
        state       <= ACK;
        wb.wb_ack_o <= 1'b1;
        wb.wb_dat_o <= rd_data;
        if (c_we) begin
          for (int n = 0; n < NUM_RW; n++) begin
            if (c_adr == 7'(n)) begin
              csr[n]      <= c_dat;
              csr_wr_o[n] <= 1'b1;
            end
          end
          if (c_adr == ADR_MASK) evt_mask <= c_dat;
        end
      end else begin
        case (state)
          IDLE: begin
            if (req) begin
              adr_q    <= wb.wb_adr_i;
              we_q     <= wb.wb_we_i;
              dat_q    <= wb.wb_dat_i;
              snap_q   <= cnt;
              wait_cnt <= 4'd0;
              state    <= WAIT;
            end
          end
          WAIT: begin
            if (!wb.wb_cyc_i) state <= IDLE;
            else              wait_cnt <= wait_cnt + 4'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar n = 0; n < NUM_RW; n++) begin : g_csr_q
    assign csr_q[8*n +: 8] = csr[n];
  end

endmodule

// File: tb/tb_wb_csr_bank.sv
// tb/tb_wb_csr_bank.sv - directed bench for wb_csr_bank with zero and three wait states
module tb_wb_csr_bank;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   evt = 8'h00;
  logic [127:0] csr_q0, csr_q3;
  logic [15:0]  csr_wr0, csr_wr3;
  logic         irq0, irq3;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc_cnt = 0;

  logic [7:0]  r_dat, r_dat_after;
  logic [15:0] r_wr;
  logic        r_ack_after, r_irq_ack, r_irq_after;
  int          r_lat, r_e0;

  wb_csr_bank_if bus0 ();
  wb_csr_bank_if bus3 ();

  wb_csr_bank #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .wb(bus0.slave),
    .csr_q(csr_q0), .csr_wr_o(csr_wr0), .evt_i(evt), .irq_o(irq0)
  );

  wb_csr_bank #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .wb(bus3.slave),
    .csr_q(csr_q3), .csr_wr_o(csr_wr3), .evt_i(8'h00), .irq_o(irq3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic [6:0] adr, input logic we,
                       input logic [7:0] dat, input logic stb, input logic cyc);
    if (w == 0) begin
      bus0.wb_adr_i = adr; bus0.wb_we_i = we; bus0.wb_dat_i = dat;
      bus0.wb_stb_i = stb; bus0.wb_cyc_i = cyc;
    end else begin
      bus3.wb_adr_i = adr; bus3.wb_we_i = we; bus3.wb_dat_i = dat;
      bus3.wb_stb_i = stb; bus3.wb_cyc_i = cyc;
    end
  endtask

  function automatic logic ack_of(input int w);
    return (w == 0) ? bus0.wb_ack_o : bus3.wb_ack_o;
  endfunction

  // Called at a negedge; 1-cycle stb with cyc held until one cycle past ack.
  task automatic xfer(input int w, input logic [6:0] adr, input logic we, input logic [7:0] dat);
    drive(w, adr, we, dat, 1'b1, 1'b1);
    r_e0 = cyc_cnt;
    @(posedge clk); #1;
    drive(w, adr, we, dat, 1'b0, 1'b1);
    r_lat = 1;
    while (!ack_of(w) && r_lat < 20) begin
      @(posedge clk); #1;
      r_lat++;
    end
    r_dat     = (w == 0) ? bus0.wb_dat_o : bus3.wb_dat_o;
    r_wr      = (w == 0) ? csr_wr0 : csr_wr3;
    r_irq_ack = irq0;
    @(posedge clk); #1;
    r_ack_after = ack_of(w);
    r_dat_after = (w == 0) ? bus0.wb_dat_o : bus3.wb_dat_o;
    r_irq_after = irq0;
    drive(w, 7'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  // Watches n cycles and returns how many had ack high on the chosen bus.
  task automatic count_acks(input int w, input int n, output int acks);
    acks = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (ack_of(w)) acks++;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0]   c1, c2;
    int           e1, e2, acks;
    logic [127:0] q_prev;

    drive(0, 7'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(3, 7'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_ack", bus0.wb_ack_o, 1'b0);
    check("rst_dat", bus0.wb_dat_o, 8'h00);
    check("rst_csr_q", csr_q0, 128'h0);
    check("rst_csr_wr", csr_wr0, 16'h0);
    check("rst_irq", irq0, 1'b0);

    xfer(0, 7'h70, 1'b0, 8'h00);
    check("id_lat", r_lat, 1);
    check("id_dat", r_dat, 8'hA5);
    check("id_ack_width", r_ack_after, 1'b0);
    check("id_dat_after", r_dat_after, 8'h00);

    xfer(0, 7'h05, 1'b1, 8'h3C);
    check("wr5_lat", r_lat, 1);
    check("wr5_pulse", r_wr, 16'h0020);
    check("wr5_pulse_end", csr_wr0, 16'h0000);
    check("wr5_q", csr_q0[47:40], 8'h3C);
    check("wr5_q_whole", csr_q0, 128'h0000_0000_0000_0000_0000_3C00_0000_0000);
    xfer(0, 7'h05, 1'b0, 8'h00);
    check("rd5_dat", r_dat, 8'h3C);
    check("rd5_no_pulse", r_wr, 16'h0000);

    xfer(0, 7'h55, 1'b0, 8'h00);
    check("unmap_rd_lat", r_lat, 1);
    check("unmap_rd_dat", r_dat, 8'h00);
    q_prev = csr_q0;
    xfer(0, 7'h55, 1'b1, 8'hFF);
    check("unmap_wr_lat", r_lat, 1);
    check("unmap_wr_q", csr_q0, q_prev);
    check("unmap_wr_pulse", r_wr, 16'h0000);

    xfer(0, 7'h71, 1'b0, 8'h00);
    c1 = r_dat; e1 = r_e0;
    repeat (40) @(negedge clk);
    xfer(0, 7'h71, 1'b0, 8'h00);
    c2 = r_dat; e2 = r_e0;
    check("cnt_delta", 8'(c2 - c1), 8'(e2 - e1));

    xfer(0, 7'h73, 1'b1, 8'h08);
    xfer(0, 7'h73, 1'b0, 8'h00);
    check("mask_rd", r_dat, 8'h08);
    evt = 8'h08;
    @(posedge clk); #1;
    check("irq_lag", irq0, 1'b0);
    @(posedge clk); #1;
    check("irq_set", irq0, 1'b1);
    @(negedge clk);
    evt = 8'h00;
    @(negedge clk);
    xfer(0, 7'h72, 1'b0, 8'h00);
    check("status_set", r_dat, 8'h08);

    evt = 8'h08;
    xfer(0, 7'h72, 1'b1, 8'h08);
    evt = 8'h00;
    check("w1c_vs_set_irq", r_irq_after, 1'b1);
    xfer(0, 7'h72, 1'b0, 8'h00);
    check("w1c_vs_set_status", r_dat, 8'h08);

    xfer(0, 7'h72, 1'b1, 8'h08);
    check("w1c_irq_at_ack", r_irq_ack, 1'b1);
    check("w1c_irq_after", r_irq_after, 1'b0);
    xfer(0, 7'h72, 1'b0, 8'h00);
    check("w1c_status", r_dat, 8'h00);

    xfer(3, 7'h70, 1'b0, 8'h00);
    check("w3_id_lat", r_lat, 4);
    check("w3_id_dat", r_dat, 8'hA5);
    check("w3_ack_width", r_ack_after, 1'b0);

    xfer(3, 7'h05, 1'b1, 8'h3C);
    check("w3_wr5_lat", r_lat, 4);
    check("w3_wr5_pulse", r_wr, 16'h0020);
    check("w3_wr5_q", csr_q3[47:40], 8'h3C);

    drive(3, 7'h02, 1'b1, 8'h77, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(3, 7'h02, 1'b1, 8'h77, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(3, 7'h02, 1'b1, 8'h77, 1'b0, 1'b0);
    count_acks(3, 8, acks);
    check("abort_no_ack", acks, 0);
    check("abort_q", csr_q3[23:16], 8'h00);
    xfer(3, 7'h02, 1'b0, 8'h00);
    check("abort_next_lat", r_lat, 4);
    check("abort_next_dat", r_dat, 8'h00);

    drive(3, 7'h01, 1'b1, 8'h11, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(3, 7'h01, 1'b1, 8'h11, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(3, 7'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    count_acks(3, 8, acks);
    check("midrst_no_ack", acks, 0);
    check("midrst_q", csr_q3[15:8], 8'h00);
    check("midrst_q5", csr_q3[47:40], 8'h00);
    xfer(3, 7'h70, 1'b0, 8'h00);
    check("midrst_recover_lat", r_lat, 4);
    check("midrst_recover_dat", r_dat, 8'hA5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
